// File: rtl/fault_sim_ctrl.sv
// fault_sim_ctrl: fault-simulation controller. It compares the faulty-CUT output with the
// fault-free output on each valid pattern, declares each injected fault detected or
// undetected, steps the fault-injection logic and counts detected and total faults.
// Optional build macro FAULT_SIM_PAT_SUM_EN adds the pat_sum total-patterns accumulator.
module fault_sim_ctrl #(
    parameter int unsigned OUT_BITS = 32,
    parameter int unsigned MAX_PATS = 1024,
    parameter int unsigned PAT_W    = 16,
    parameter int unsigned CNT_W    = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic                      pat_valid,
    input  logic [OUT_BITS-1:0]       CUT_OP,
    input  logic [OUT_BITS-1:0]       FF_OP,
    input  logic                      FIL_END,
    output logic                      FIL_INC,
    output logic                      pat_en,
    output logic                      pat_restart,
    output logic                      busy,
    output logic                      done,
    output logic [CNT_W-1:0]          det_cnt,
    output logic [CNT_W-1:0]          tot_cnt
`ifdef FAULT_SIM_PAT_SUM_EN
    ,
    output logic [PAT_W+CNT_W-1:0]    pat_sum
`endif
);

    typedef enum logic [2:0] {StIdle, StRun, StNext, StSettle, StDone} state_e;

    // Index of the final pattern a fault may receive before it is declared undetected.
    localparam logic [PAT_W-1:0] LastPat = PAT_W'(MAX_PATS - 1);

    state_e             state_q, state_d;
    logic [PAT_W-1:0]   pat_cnt_q, pat_cnt_d;
    logic               det_q, det_d;
    logic [CNT_W-1:0]   det_cnt_q, det_cnt_d;
    logic [CNT_W-1:0]   tot_cnt_q, tot_cnt_d;
    logic               mismatch;

    assign mismatch = (CUT_OP != FF_OP);
    assign det_cnt  = det_cnt_q;
    assign tot_cnt  = tot_cnt_q;

`ifdef FAULT_SIM_PAT_SUM_EN
    localparam int unsigned SumW = PAT_W + CNT_W;

    logic [SumW-1:0] sum_q, sum_d;
    logic [SumW:0]   sum_ext;

    // One extra bit catches the carry so the accumulator can saturate instead of wrapping.
    assign sum_ext = {1'b0, sum_q} + (SumW + 1)'(pat_cnt_q) + (SumW + 1)'(1);
    assign pat_sum = sum_q;

    // Total-patterns accumulator register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sum_q <= '0;
        end else begin
            sum_q <= sum_d;
        end
    end
`endif

    // State, pattern counter, detect flag and fault counters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= StIdle;
            pat_cnt_q <= '0;
            det_q     <= 1'b0;
            det_cnt_q <= '0;
            tot_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            pat_cnt_q <= pat_cnt_d;
            det_q     <= det_d;
            det_cnt_q <= det_cnt_d;
            tot_cnt_q <= tot_cnt_d;
        end
    end

    // Next-state logic and handshake outputs.
    always_comb begin
        state_d     = state_q;
        pat_cnt_d   = pat_cnt_q;
        det_d       = det_q;
        det_cnt_d   = det_cnt_q;
        tot_cnt_d   = tot_cnt_q;
`ifdef FAULT_SIM_PAT_SUM_EN
        sum_d       = sum_q;
`endif
        FIL_INC     = 1'b0;
        pat_en      = 1'b0;
        pat_restart = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;

        unique case (state_q)
            StIdle: begin
                // Qualified by rst so pat_restart stays low while reset is held.
                if (start && rst) begin
                    pat_restart = 1'b1;
                    pat_cnt_d   = '0;
                    det_d       = 1'b0;
                    det_cnt_d   = '0;
                    tot_cnt_d   = '0;
`ifdef FAULT_SIM_PAT_SUM_EN
                    sum_d       = '0;
`endif
                    state_d     = StRun;
                end
            end
            StRun: begin
                pat_en = 1'b1;
                busy   = 1'b1;
                if (pat_valid) begin
                    // Mismatch wins over timeout on the last allowed pattern.
                    if (mismatch) begin
                        det_d   = 1'b1;
                        state_d = StNext;
                    end else if (pat_cnt_q == LastPat) begin
                        det_d   = 1'b0;
                        state_d = StNext;
                    end else begin
                        pat_cnt_d = pat_cnt_q + PAT_W'(1);
                    end
                end
            end
            StNext: begin
                busy = 1'b1;
                if (tot_cnt_q != '1) begin
                    tot_cnt_d = tot_cnt_q + CNT_W'(1);
                end
                if (det_q && (det_cnt_q != '1)) begin
                    det_cnt_d = det_cnt_q + CNT_W'(1);
                end
`ifdef FAULT_SIM_PAT_SUM_EN
                sum_d = sum_ext[SumW] ? '1 : sum_ext[SumW-1:0];
`endif
                if (FIL_END) begin
                    state_d = StDone;
                end else begin
                    FIL_INC     = 1'b1;
                    pat_restart = 1'b1;
                    det_d       = 1'b0;
                    pat_cnt_d   = '0;
                    state_d     = StSettle;
                end
            end
            StSettle: begin
                busy    = 1'b1;
                state_d = StRun;
            end
            StDone: begin
                done = 1'b1;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

endmodule

// File: tb/tb_fault_sim_ctrl.sv
// tb_fault_sim_ctrl: table-driven and randomized campaigns against a fault-list model.
// The bench plays the pattern generator and fault-injection logic; each fault is described
// by the pattern number at which it first mismatches (0 = never).
module tb_fault_sim_ctrl;

    localparam int OB   = 8;
    localparam int MP   = 8;
    localparam int PW   = 4;
    localparam int CW   = 4;
    localparam int SW   = PW + CW;
    localparam int MAXF = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic          pat_valid = 1'b0;
    logic          FIL_END = 1'b0;
    logic [OB-1:0] CUT_OP = '0;
    logic [OB-1:0] FF_OP = '0;
    logic          FIL_INC, pat_en, pat_restart, busy, done;
    logic [CW-1:0] det_cnt, tot_cnt;
`ifdef FAULT_SIM_PAT_SUM_EN
    logic [SW-1:0] pat_sum;
`endif

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        int          n;
        logic [31:0] d;      // nibble i = detect pattern of fault i (repeats every 8 faults)
        int          vpct;
        int          e_det;
        int          e_tot;
        int          e_sum;
        int          e_busy; // -1 = not checked
    } vec_t;

    vec_t tbl[8];

    always #5 clk = ~clk;

    fault_sim_ctrl #(
        .OUT_BITS (OB),
        .MAX_PATS (MP),
        .PAT_W    (PW),
        .CNT_W    (CW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .pat_valid   (pat_valid),
        .CUT_OP      (CUT_OP),
        .FF_OP       (FF_OP),
        .FIL_END     (FIL_END),
        .FIL_INC     (FIL_INC),
        .pat_en      (pat_en),
        .pat_restart (pat_restart),
        .busy        (busy),
        .done        (done),
        .det_cnt     (det_cnt),
        .tot_cnt     (tot_cnt)
`ifdef FAULT_SIM_PAT_SUM_EN
        ,
        .pat_sum     (pat_sum)
`endif
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int sat(input int v, input int w);
        return (v > (1 << w) - 1) ? (1 << w) - 1 : v;
    endfunction

    // Patterns a fault consumes: its detect pattern, or the full budget if never detected.
    function automatic int pm(input int d);
        return (d == 0) ? MP : d;
    endfunction

    task automatic do_reset(input string tag);
        @(negedge clk);
        rst = 1'b0;
        start = 1'b0;
        pat_valid = 1'b0;
        #1;
        check({tag, "_rst_outs"}, {FIL_INC, pat_en, pat_restart, busy, done, det_cnt, tot_cnt}, 0);
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic run_campaign(input string tag, input int n, input int d[MAXF], input int vpct,
                                input int e_det, input int e_tot, input int e_sum,
                                input int e_busy, input int abort_at, output bit aborted);
        int fi = 0, hs = 0, busy_cyc = 0, incs = 0, rsts = 0, cyc = 0, fd;
        bit fin = 1'b0, mm;
        aborted = 1'b0;
        do_reset(tag);
        while (!fin && cyc < 3000) begin
            start = (cyc == 0);
            fd = (fi < n) ? d[fi] : 0;
            FF_OP = OB'($urandom);
            if (pat_en) begin
                pat_valid = ($urandom_range(99) < vpct);
                FIL_END = 1'($urandom);
                mm = pat_valid && (hs + 1 == fd);
                if (pat_valid) CUT_OP = mm ? FF_OP ^ OB'($urandom_range(255, 1)) : FF_OP;
                else CUT_OP = OB'($urandom);
            end else begin
                pat_valid = 1'($urandom);
                FIL_END = (fi == n - 1);
                CUT_OP = OB'($urandom);
            end
            #1;
            if (busy) busy_cyc++;
            if (pat_restart) rsts++;
            if (pat_en && pat_valid) hs++;
            if (FIL_INC) begin
                incs++;
                check($sformatf("%s_pats_f%0d", tag, fi), hs, pm(fd));
                fi++;
                hs = 0;
            end
            if (abort_at > 0 && fi == abort_at && pat_en) begin
                aborted = 1'b1;
                fin = 1'b1;
            end
            if (done) fin = 1'b1;
            cyc++;
            if (!fin) @(negedge clk);
        end
        start = 1'b0;
        check({tag, "_finished"}, fin, 1);
        if (!aborted) begin
            check({tag, "_pats_last"}, hs, pm(d[n - 1]));
            check({tag, "_fil_inc"}, incs, n - 1);
            check({tag, "_restarts"}, rsts, n);
            check({tag, "_det"}, det_cnt, e_det);
            check({tag, "_tot"}, tot_cnt, e_tot);
`ifdef FAULT_SIM_PAT_SUM_EN
            check({tag, "_pat_sum"}, pat_sum, e_sum);
`endif
            if (e_busy >= 0) check({tag, "_busy_cycles"}, busy_cyc, e_busy);
            // start held high in DONE must change nothing.
            for (int k = 0; k < 3; k++) begin
                @(negedge clk);
                start = 1'b1;
                pat_valid = 1'($urandom);
                FIL_END = 1'($urandom);
                CUT_OP = OB'($urandom);
                FF_OP = ~CUT_OP;
                #1;
                check({tag, "_done_hold"}, {done, busy, pat_en, pat_restart, FIL_INC}, 5'b10000);
            end
            check({tag, "_det_frozen"}, det_cnt, e_det);
            check({tag, "_tot_frozen"}, tot_cnt, e_tot);
            start = 1'b0;
        end
    endtask

    initial begin
        int  d[MAXF];
        int  n, vpct, e_det, e_sum;
        bit  ab;

        tbl[0] = '{4, 32'h00001111, 100, 4, 4, 4, 11};
        tbl[1] = '{1, 32'h00000000, 100, 0, 1, 8, 9};
        tbl[2] = '{1, 32'h00000008, 100, 1, 1, 8, 9};
        tbl[3] = '{3, 32'h00000851, 100, 3, 3, 14, 19};
        tbl[4] = '{3, 32'h00000020, 100, 1, 3, 18, 23};
        tbl[5] = '{18, 32'h22222222, 100, 15, 15, 36, 71};
        tbl[6] = '{1, 32'h00000008, 50, 1, 1, 8, -1};
        tbl[7] = '{2, 32'h00000008, 100, 1, 2, 16, 19};

        // Reset held with start and a mismatch present: everything stays at zero.
        start = 1'b1;
        pat_valid = 1'b1;
        FIL_END = 1'b1;
        CUT_OP = 8'hA5;
        FF_OP = 8'h5A;
        repeat (3) @(negedge clk);
        check("reset_held_outs",
              {FIL_INC, pat_en, pat_restart, busy, done, det_cnt, tot_cnt}, 0);
        start = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        check("idle_after_reset", {busy, done, pat_en, pat_restart}, 0);

        for (int t = 0; t < 8; t++) begin
            for (int i = 0; i < MAXF; i++) d[i] = int'(tbl[t].d[(i % 8) * 4 +: 4]);
            run_campaign($sformatf("tbl%0d", t), tbl[t].n, d, tbl[t].vpct, tbl[t].e_det,
                         tbl[t].e_tot, tbl[t].e_sum, tbl[t].e_busy, 0, ab);
        end

        // Reset while the fourth fault is running, after three faults were evaluated.
        for (int i = 0; i < MAXF; i++) d[i] = 1;
        run_campaign("abort", 5, d, 100, 0, 0, 0, -1, 3, ab);
        check("abort_reached", ab, 1);
        check("abort_tot_before", tot_cnt, 3);
        rst = 1'b0;
        #1;
        check("abort_outs", {FIL_INC, pat_en, pat_restart, busy, done, det_cnt, tot_cnt}, 0);
        run_campaign("rerun", 5, d, 100, 5, 5, 5, 5 + 9, 0, ab);

        // Randomized campaigns checked against the fault-list model.
        for (int r = 0; r < 10; r++) begin
            n = (r == 0) ? 20 : $urandom_range(20, 1);
            vpct = (r % 3 == 0) ? 100 : $urandom_range(99, 40);
            e_det = 0;
            e_sum = 0;
            for (int i = 0; i < MAXF; i++) d[i] = $urandom_range(MP, 0);
            for (int i = 0; i < n; i++) begin
                e_det += (d[i] != 0) ? 1 : 0;
                e_sum += pm(d[i]);
            end
            run_campaign($sformatf("rnd%0d", r), n, d, vpct, sat(e_det, CW), sat(n, CW),
                         sat(e_sum, SW), (vpct == 100) ? e_sum + 2 * n - 1 : -1, 0, ab);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
